rv32_hazard_ctrl: RTL and testbench
===================================

# rv32_hazard_ctrl

Pipeline sequencer for the five-stage rv32 core (fetch, decode, execute, mem, writeback). It consumes the decode stage's unregistered hazard outputs plus status from the later stages, and drives every stage's stall and flush controls. It implements, in fixed priority order: trap flush, data-bus stall, branch-mispredict flush, load-use interlock, fence drain and instruction-bus bubble. A small FSM sequences multi-cycle trap flushes and fence drains, and a counter records stall cycles.

## Interface
- TRAP_FLUSH_CYCLES, 1: extra cycles (1–15) that fetch/decode stay flushed after a trap.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- decode_valid_in  in  1  decode holds a valid instruction.
- decode_rs1_unreg_in / decode_rs2_unreg_in  in  5 each  decode source register numbers.
- decode_rs1_read_unreg_in / decode_rs2_read_unreg_in  in  1 each  source is actually read.
- decode_mem_fence_unreg_in  in  1  decode holds a fence.
- execute_valid_in  in  1  execute holds a valid instruction.
- execute_mem_read_in  in  1  execute holds a load.
- execute_rd_in  in  5  execute destination register.
- execute_branch_mispredicted_in  in  1  branch resolved in execute was mispredicted.
- mem_valid_in  in  1  mem holds a valid instruction.
- mem_trap_in  in  1  trap is taken at mem this cycle.
- instr_busy_in / data_busy_in  in  1 each  instruction/data bus transaction not yet complete.
- fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out  out  1 each  hold the stage output register.
- fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out, writeback_flush_out  out  1 each  squash the stage output register.
- fence_active_out  out  1  FSM is in FENCE.
- stall_cycles_out  out  32  count of cycles with decode_stall_out high; wraps.

## Operation
- Stage outputs are combinational from the FSM state and the inputs. FSM state and counters are registered.
- FSM states: RUN, TRAP, FENCE.
- Priority, highest first:
  1. mem_trap_in in any state: flush fetch, decode, execute and mem; load trap counter with TRAP_FLUSH_CYCLES; go to TRAP. This also aborts FENCE.
  2. TRAP state: flush fetch and decode; decrement the counter; return to RUN when the counter reaches 1 (after that cycle).
  3. data_busy_in: stall fetch, decode, execute and mem; assert writeback_flush_out. This masks a mispredict, which re-asserts while the branch is held.
  4. execute_branch_mispredicted_in && execute_valid_in: flush fetch and decode.
  5. Load-use: execute_valid_in && execute_mem_read_in && execute_rd_in≠0 && ((rs1_read && rs1==rd) || (rs2_read && rs2==rd)). Stall fetch and decode; flush execute.
  6. Fence: decode_valid_in && decode_mem_fence_unreg_in && (execute_valid_in || mem_valid_in).
     - From RUN, go to FENCE.
     - In FENCE: stall fetch and decode; flush execute.
     - Leave FENCE on the first cycle with execute_valid_in=0, mem_valid_in=0 and data_busy_in=0. That cycle has no stall, the fence advances, and the next state is RUN.
     - A fence with an already empty pipeline causes no stall.
  7. instr_busy_in: stall fetch; flush decode (bubble).
- Flush asserted on a stalled stage: flush wins. This is rule-guaranteed and is never produced by the priorities above.
- stall_cycles_out increments whenever decode_stall_out=1, wrapping from 0xFFFFFFFF to 0.

## Timing
- While reset is high, and on the first cycle after its release:
  - State RUN; trap counter 0; stall_cycles_out 0.
  - All *_flush_out=1; all *_stall_out=0; fence_active_out=0.
- Reset mid-TRAP or mid-FENCE abandons the sequence immediately.
- Zero-cycle latency from inputs to stall/flush outputs.
- Trap: flush is visible in the same cycle as mem_trap_in. Fetch/decode flush then continues for exactly TRAP_FLUSH_CYCLES following cycles.
- mem_trap_in asserted during TRAP reloads the counter (restart).
- Fence entry and exit are decided in the same cycle as the inputs. Minimum FENCE residency is 1 cycle.

## Structure
- Shared package rv32_hazard_pkg holds:
  - the state enum (RUN=0, TRAP=1, FENCE=2);
  - the trap-counter width of 4 bits;
  - a struct bundling the 9 stall/flush bits.
- One sub-module, rv32_load_use_detect: combinational comparator for rule 5, reusable by a later forwarding unit.

## Test plan
- Load x5 in execute, decode reads rs2=x5 -> decode_stall_out=1, execute_flush_out=1 for 1 cycle. Same with rd=x0 -> no stall.
- mem_trap_in pulse with TRAP_FLUSH_CYCLES=2 -> fetch/decode flush for 3 consecutive cycles; execute/mem flush in cycle 0 only; then RUN.
- Fence in decode with mem_valid_in high for 3 cycles -> fence_active_out and stall high for 3 cycles, released on cycle 4; stall_cycles_out +3.
- data_busy_in and mispredict both high -> only stalls and writeback_flush_out; mispredict flush appears in the cycle after data_busy_in drops.
- Trap during FENCE -> immediate TRAP, fence_active_out=0 the next cycle.
- Assert reset in TRAP -> outputs take reset values without a clock edge; stall_cycles_out preset to 0xFFFFFFFE wraps to 0 after 2 stall cycles.

Source files
------------

// File: rtl/rv32_hazard_pkg.sv
// Shared types for the rv32 pipeline hazard sequencer: FSM states, trap-counter
// width and the bundled stall/flush control word.
package rv32_hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        FENCE = 2'd2
    } hz_state_e;

    localparam int TRAP_CNT_W = 4;
    typedef logic [TRAP_CNT_W-1:0] trap_cnt_t;

    typedef struct packed {
        logic fetch_stall;
        logic decode_stall;
        logic execute_stall;
        logic mem_stall;
        logic fetch_flush;
        logic decode_flush;
        logic execute_flush;
        logic mem_flush;
        logic writeback_flush;
    } hz_ctrl_t;

    // A squashed stage has nothing worth holding, so flush overrides stall.
    function automatic hz_ctrl_t resolve_ctrl(input hz_ctrl_t c);
        hz_ctrl_t r;
        r = c;
        r.fetch_stall   = c.fetch_stall   & ~c.fetch_flush;
        r.decode_stall  = c.decode_stall  & ~c.decode_flush;
        r.execute_stall = c.execute_stall & ~c.execute_flush;
        r.mem_stall     = c.mem_stall     & ~c.mem_flush;
        return r;
    endfunction

endpackage

// File: rtl/rv32_hazard_ctrl_if.sv
// Pipeline status in / stage control out bundle between the rv32 pipeline
// (master) and the hazard sequencer (slave).
interface rv32_hazard_ctrl_if;
    logic       decode_valid_in;
    logic [4:0] decode_rs1_unreg_in;
    logic [4:0] decode_rs2_unreg_in;
    logic       decode_rs1_read_unreg_in;
    logic       decode_rs2_read_unreg_in;
    logic       decode_mem_fence_unreg_in;
    logic       execute_valid_in;
    logic       execute_mem_read_in;
    logic [4:0] execute_rd_in;
    logic       execute_branch_mispredicted_in;
    logic       mem_valid_in;
    logic       mem_trap_in;
    logic       instr_busy_in;
    logic       data_busy_in;

    logic        fetch_stall_out;
    logic        decode_stall_out;
    logic        execute_stall_out;
    logic        mem_stall_out;
    logic        fetch_flush_out;
    logic        decode_flush_out;
    logic        execute_flush_out;
    logic        mem_flush_out;
    logic        writeback_flush_out;
    logic        fence_active_out;
    logic [31:0] stall_cycles_out;

    modport master (
        output decode_valid_in, decode_rs1_unreg_in, decode_rs2_unreg_in,
               decode_rs1_read_unreg_in, decode_rs2_read_unreg_in,
               decode_mem_fence_unreg_in, execute_valid_in, execute_mem_read_in,
               execute_rd_in, execute_branch_mispredicted_in, mem_valid_in,
               mem_trap_in, instr_busy_in, data_busy_in,
        input  fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
               fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
               writeback_flush_out, fence_active_out, stall_cycles_out
    );

    modport slave (
        input  decode_valid_in, decode_rs1_unreg_in, decode_rs2_unreg_in,
               decode_rs1_read_unreg_in, decode_rs2_read_unreg_in,
               decode_mem_fence_unreg_in, execute_valid_in, execute_mem_read_in,
               execute_rd_in, execute_branch_mispredicted_in, mem_valid_in,
               mem_trap_in, instr_busy_in, data_busy_in,
        output fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out,
               fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out,
               writeback_flush_out, fence_active_out, stall_cycles_out
    );
endinterface

// File: rtl/rv32_load_use_detect.sv
// Load-use comparator: a load in execute whose destination is read by the
// instruction in decode. x0 never creates a dependency.
module rv32_load_use_detect (
    input  logic       execute_valid,
    input  logic       execute_mem_read,
    input  logic [4:0] execute_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs1_read,
    input  logic       rs2_read,
    output logic       hit
);
    logic rs1_match, rs2_match;

    assign rs1_match = rs1_read && (rs1 == execute_rd);
    assign rs2_match = rs2_read && (rs2 == execute_rd);
    assign hit = execute_valid && execute_mem_read && (execute_rd != 5'd0) &&
                 (rs1_match || rs2_match);
endmodule

// File: rtl/rv32_hazard_ctrl.sv
// Five-stage rv32 pipeline sequencer: resolves trap, bus, mispredict, load-use
// and fence hazards into per-stage stall/flush, with a small TRAP/FENCE FSM.
module rv32_hazard_ctrl
    import rv32_hazard_pkg::*;
#(
    parameter int          TRAP_FLUSH_CYCLES = 1,
    parameter logic [31:0] STALL_CNT_RESET   = 32'd0
) (
    input logic               clk,
    input logic               reset,
    rv32_hazard_ctrl_if.slave hz
);
    hz_state_e   state, state_nxt;
    trap_cnt_t   trap_cnt, trap_cnt_nxt;
    logic        init_q;
    logic        load_use, fence_req, drained, mispredict;
    logic [31:0] stall_cnt;
    hz_ctrl_t    ctrl_raw, ctrl;

    rv32_load_use_detect u_load_use (
        .execute_valid    (hz.execute_valid_in),
        .execute_mem_read (hz.execute_mem_read_in),
        .execute_rd       (hz.execute_rd_in),
        .rs1              (hz.decode_rs1_unreg_in),
        .rs2              (hz.decode_rs2_unreg_in),
        .rs1_read         (hz.decode_rs1_read_unreg_in),
        .rs2_read         (hz.decode_rs2_read_unreg_in),
        .hit              (load_use)
    );

    assign mispredict = hz.execute_branch_mispredicted_in && hz.execute_valid_in;
    assign fence_req  = hz.decode_valid_in && hz.decode_mem_fence_unreg_in &&
                        (hz.execute_valid_in || hz.mem_valid_in);
    assign drained    = !hz.execute_valid_in && !hz.mem_valid_in && !hz.data_busy_in;

    always_comb begin
        ctrl_raw     = '0;
        state_nxt    = state;
        trap_cnt_nxt = trap_cnt;
        if (init_q) begin
            // Held for one cycle past reset release so every stage starts empty.
            ctrl_raw.fetch_flush     = 1'b1;
            ctrl_raw.decode_flush    = 1'b1;
            ctrl_raw.execute_flush   = 1'b1;
            ctrl_raw.mem_flush       = 1'b1;
            ctrl_raw.writeback_flush = 1'b1;
            state_nxt    = RUN;
            trap_cnt_nxt = '0;
        end else if (hz.mem_trap_in) begin
            ctrl_raw.fetch_flush   = 1'b1;
            ctrl_raw.decode_flush  = 1'b1;
            ctrl_raw.execute_flush = 1'b1;
            ctrl_raw.mem_flush     = 1'b1;
            trap_cnt_nxt = trap_cnt_t'(TRAP_FLUSH_CYCLES);
            state_nxt    = TRAP;
        end else if (state == TRAP) begin
            ctrl_raw.fetch_flush  = 1'b1;
            ctrl_raw.decode_flush = 1'b1;
            trap_cnt_nxt = trap_cnt - trap_cnt_t'(1);
            if (trap_cnt <= trap_cnt_t'(1))
                state_nxt = RUN;
        end else if (hz.data_busy_in) begin
            ctrl_raw.fetch_stall     = 1'b1;
            ctrl_raw.decode_stall    = 1'b1;
            ctrl_raw.execute_stall   = 1'b1;
            ctrl_raw.mem_stall       = 1'b1;
            ctrl_raw.writeback_flush = 1'b1;
        end else if (mispredict) begin
            // Squashing decode also discards any fence being drained there.
            ctrl_raw.fetch_flush  = 1'b1;
            ctrl_raw.decode_flush = 1'b1;
            state_nxt = RUN;
        end else if (load_use) begin
            ctrl_raw.fetch_stall   = 1'b1;
            ctrl_raw.decode_stall  = 1'b1;
            ctrl_raw.execute_flush = 1'b1;
        end else if (state == FENCE) begin
            if (drained) begin
                state_nxt = RUN;
            end else begin
                ctrl_raw.fetch_stall   = 1'b1;
                ctrl_raw.decode_stall  = 1'b1;
                ctrl_raw.execute_flush = 1'b1;
            end
        end else if (fence_req) begin
            ctrl_raw.fetch_stall   = 1'b1;
            ctrl_raw.decode_stall  = 1'b1;
            ctrl_raw.execute_flush = 1'b1;
            state_nxt = FENCE;
        end else if (hz.instr_busy_in) begin
            ctrl_raw.fetch_stall  = 1'b1;
            ctrl_raw.decode_flush = 1'b1;
        end
    end

    assign ctrl = resolve_ctrl(ctrl_raw);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            trap_cnt  <= '0;
            init_q    <= 1'b1;
            stall_cnt <= STALL_CNT_RESET;
        end else begin
            state    <= state_nxt;
            trap_cnt <= trap_cnt_nxt;
            init_q   <= 1'b0;
            if (ctrl.decode_stall)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign hz.fetch_stall_out     = ctrl.fetch_stall;
    assign hz.decode_stall_out    = ctrl.decode_stall;
    assign hz.execute_stall_out   = ctrl.execute_stall;
    assign hz.mem_stall_out       = ctrl.mem_stall;
    assign hz.fetch_flush_out     = ctrl.fetch_flush;
    assign hz.decode_flush_out    = ctrl.decode_flush;
    assign hz.execute_flush_out   = ctrl.execute_flush;
    assign hz.mem_flush_out       = ctrl.mem_flush;
    assign hz.writeback_flush_out = ctrl.writeback_flush;
    assign hz.fence_active_out    = (state == FENCE);
    assign hz.stall_cycles_out    = stall_cnt;
endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed bench for rv32_hazard_ctrl: stimulus queues hand-computed expected
// controls per cycle, a negedge monitor pops and compares.
module tb_rv32_hazard_ctrl;
    localparam int TFC = 2;
    // {fs,ds,es,ms, ff,df,ef,mf,wf}
    localparam logic [8:0] NONE = 9'b0000_00000;
    localparam logic [8:0] RSTV = 9'b0000_11111;
    localparam logic [8:0] LU   = 9'b1100_00100;
    localparam logic [8:0] TRP0 = 9'b0000_11110;
    localparam logic [8:0] FD   = 9'b0000_11000;
    localparam logic [8:0] DBSY = 9'b1111_00001;
    localparam logic [8:0] IBSY = 9'b1000_01000;

    typedef struct {
        logic [8:0]  c;
        logic        fa;
        logic [31:0] cnt;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exp_t        q[$];
    exp_t        mon_e;
    logic [8:0]  act;
    logic [31:0] exp_cnt = 32'd0;
    int          vec = 0;
    int          checks = 0;
    int          errors = 0;

    rv32_hazard_ctrl_if hm();
    rv32_hazard_ctrl_if hw();

    assign hw.decode_valid_in                = hm.decode_valid_in;
    assign hw.decode_rs1_unreg_in            = hm.decode_rs1_unreg_in;
    assign hw.decode_rs2_unreg_in            = hm.decode_rs2_unreg_in;
    assign hw.decode_rs1_read_unreg_in       = hm.decode_rs1_read_unreg_in;
    assign hw.decode_rs2_read_unreg_in       = hm.decode_rs2_read_unreg_in;
    assign hw.decode_mem_fence_unreg_in      = hm.decode_mem_fence_unreg_in;
    assign hw.execute_valid_in               = hm.execute_valid_in;
    assign hw.execute_mem_read_in            = hm.execute_mem_read_in;
    assign hw.execute_rd_in                  = hm.execute_rd_in;
    assign hw.execute_branch_mispredicted_in = hm.execute_branch_mispredicted_in;
    assign hw.mem_valid_in                   = hm.mem_valid_in;
    assign hw.mem_trap_in                    = hm.mem_trap_in;
    assign hw.instr_busy_in                  = hm.instr_busy_in;
    assign hw.data_busy_in                   = hm.data_busy_in;

    rv32_hazard_ctrl #(.TRAP_FLUSH_CYCLES(TFC)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hm.slave)
    );

    // Same stimulus, counter starting near the top to exercise the wrap.
    rv32_hazard_ctrl #(.TRAP_FLUSH_CYCLES(TFC), .STALL_CNT_RESET(32'hFFFF_FFFE)) dut_w (
        .clk   (clk),
        .reset (reset),
        .hz    (hw.slave)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, id, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            act = {hm.fetch_stall_out, hm.decode_stall_out, hm.execute_stall_out,
                   hm.mem_stall_out, hm.fetch_flush_out, hm.decode_flush_out,
                   hm.execute_flush_out, hm.mem_flush_out, hm.writeback_flush_out};
            chk("ctrl", mon_e.id, {23'd0, act}, {23'd0, mon_e.c});
            chk("fence_active", mon_e.id, {31'd0, hm.fence_active_out}, {31'd0, mon_e.fa});
            chk("stall_cycles", mon_e.id, hm.stall_cycles_out, mon_e.cnt);
            chk("stall_cycles_wrap", mon_e.id, hw.stall_cycles_out, mon_e.cnt + 32'hFFFF_FFFE);
        end
    end

    task automatic clear();
        hm.decode_valid_in                = 1'b0;
        hm.decode_rs1_unreg_in            = 5'd0;
        hm.decode_rs2_unreg_in            = 5'd0;
        hm.decode_rs1_read_unreg_in       = 1'b0;
        hm.decode_rs2_read_unreg_in       = 1'b0;
        hm.decode_mem_fence_unreg_in      = 1'b0;
        hm.execute_valid_in               = 1'b0;
        hm.execute_mem_read_in            = 1'b0;
        hm.execute_rd_in                  = 5'd0;
        hm.execute_branch_mispredicted_in = 1'b0;
        hm.mem_valid_in                   = 1'b0;
        hm.mem_trap_in                    = 1'b0;
        hm.instr_busy_in                  = 1'b0;
        hm.data_busy_in                   = 1'b0;
    endtask

    // Queue this cycle's expectation, then advance one clock and idle the inputs.
    task automatic step(input logic [8:0] c, input logic fa);
        exp_t e;
        e.c = c; e.fa = fa; e.cnt = exp_cnt; e.id = vec;
        q.push_back(e);
        vec++;
        if (c[7]) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk); #1;
        clear();
    endtask

    task automatic ld(input logic [4:0] rd);
        hm.execute_valid_in    = 1'b1;
        hm.execute_mem_read_in = 1'b1;
        hm.execute_rd_in       = rd;
        hm.decode_valid_in     = 1'b1;
    endtask

    task automatic fence();
        hm.decode_valid_in           = 1'b1;
        hm.decode_mem_fence_unreg_in = 1'b1;
    endtask

    initial begin
        clear();
        reset = 1'b1;
        @(posedge clk); #1;
        step(RSTV, 0);
        reset = 1'b0; step(RSTV, 0);
        step(NONE, 0);

        // load-use
        ld(5'd5); hm.decode_rs2_unreg_in = 5'd5; hm.decode_rs2_read_unreg_in = 1'b1; step(LU, 0);
        ld(5'd5); hm.decode_rs1_unreg_in = 5'd5; hm.decode_rs1_read_unreg_in = 1'b1; step(LU, 0);
        ld(5'd5); hm.decode_rs2_unreg_in = 5'd5; step(NONE, 0);
        ld(5'd0); hm.decode_rs2_read_unreg_in = 1'b1; step(NONE, 0);
        ld(5'd5); hm.execute_valid_in = 1'b0;
        hm.decode_rs1_unreg_in = 5'd5; hm.decode_rs1_read_unreg_in = 1'b1; step(NONE, 0);

        // trap flush, data_busy during TRAP is ignored
        hm.mem_trap_in = 1'b1; step(TRP0, 0);
        step(FD, 0);
        hm.data_busy_in = 1'b1; step(FD, 0);
        step(NONE, 0);

        // trap restart
        hm.mem_trap_in = 1'b1; step(TRP0, 0);
        step(FD, 0);
        hm.mem_trap_in = 1'b1; step(TRP0, 0);
        step(FD, 0);
        step(FD, 0);
        step(NONE, 0);

        // data bus stall masks mispredict
        hm.data_busy_in = 1'b1; hm.execute_valid_in = 1'b1; hm.execute_branch_mispredicted_in = 1'b1; step(DBSY, 0);
        hm.data_busy_in = 1'b1; hm.execute_valid_in = 1'b1; hm.execute_branch_mispredicted_in = 1'b1; step(DBSY, 0);
        hm.execute_valid_in = 1'b1; hm.execute_branch_mispredicted_in = 1'b1; step(FD, 0);
        step(NONE, 0);
        ld(5'd5); hm.decode_rs1_unreg_in = 5'd5; hm.decode_rs1_read_unreg_in = 1'b1;
        hm.data_busy_in = 1'b1; step(DBSY, 0);

        // fence drain behind a mem-stage instruction
        for (int i = 0; i < 3; i++) begin
            fence(); hm.mem_valid_in = 1'b1; step(LU, (i != 0));
        end
        fence(); step(NONE, 1);
        step(NONE, 0);
        fence(); step(NONE, 0);

        // instruction bus bubble, lower than load-use
        hm.instr_busy_in = 1'b1; step(IBSY, 0);
        hm.instr_busy_in = 1'b1; ld(5'd7);
        hm.decode_rs1_unreg_in = 5'd7; hm.decode_rs1_read_unreg_in = 1'b1; step(LU, 0);

        // trap aborts fence
        fence(); hm.execute_valid_in = 1'b1; step(LU, 0);
        fence(); hm.execute_valid_in = 1'b1; hm.mem_trap_in = 1'b1; step(TRP0, 1);
        step(FD, 0);
        step(FD, 0);
        step(NONE, 0);

        // data bus busy keeps fence resident
        fence(); hm.mem_valid_in = 1'b1; step(LU, 0);
        fence(); hm.data_busy_in = 1'b1; step(DBSY, 1);
        fence(); step(NONE, 1);
        step(NONE, 0);

        // reset mid-TRAP, then counter wrap on the preset instance
        hm.mem_trap_in = 1'b1; step(TRP0, 0);
        step(FD, 0);
        reset = 1'b1; exp_cnt = 32'd0; step(RSTV, 0);
        reset = 1'b0; step(RSTV, 0);
        step(NONE, 0);
        ld(5'd9); hm.decode_rs2_unreg_in = 5'd9; hm.decode_rs2_read_unreg_in = 1'b1; step(LU, 0);
        ld(5'd9); hm.decode_rs2_unreg_in = 5'd9; hm.decode_rs2_read_unreg_in = 1'b1; step(LU, 0);
        step(NONE, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
